// File: rtl/debug_unit_receive.sv
// ---------------------------------------------------------------------------
// debug_unit_receive
//   Host-to-MIPS half of the debug unit. Consumes bytes from the UART
//   receiver, decodes host commands, loads program words into instruction
//   memory and drives run/step control toward the pipeline.
//
//   Commands (first byte, decoded in IDLE):
//     'L' 0x4C  load program: <N> then N words, 4 bytes each, MSB first
//     'C' 0x43  run in continuous mode
//     'S' 0x53  run in step-by-step mode
//     'N' 0x4E  advance a single cycle (step mode only)
//
// Ports
//   i_clock            system clock
//   i_reset            synchronous, active-high reset
//   i_uart_rx_data     received byte, valid while i_uart_rx_done=1
//   i_uart_rx_done     1-cycle pulse: byte received
//   i_halt             pipeline reached HALT (level or pulse)
//   o_instr_mem_wr_en  1-cycle instruction memory write strobe
//   o_instr_mem_addr   word address of the write
//   o_instr_mem_data   assembled instruction word
//   o_execution_mode   0=continuous, 1=step-by-step
//   o_start            1-cycle pulse: release pipeline
//   o_step             1-cycle pulse: advance one cycle
//   o_running          program executing (set by start, cleared by halt)
//   o_program_loaded   a complete program is resident
//   o_cmd_error        1-cycle pulse: byte rejected
// ---------------------------------------------------------------------------
module debug_unit_receive #(
  parameter int NB_DATA  = 32,
  parameter int NB_BYTE  = 8,
  parameter int NB_ADDR  = 8,
  parameter int NB_STATE = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_uart_rx_data,
  input  logic               i_uart_rx_done,
  input  logic               i_halt,
  output logic               o_instr_mem_wr_en,
  output logic [NB_ADDR-1:0] o_instr_mem_addr,
  output logic [NB_DATA-1:0] o_instr_mem_data,
  output logic               o_execution_mode,
  output logic               o_start,
  output logic               o_step,
  output logic               o_running,
  output logic               o_program_loaded,
  output logic               o_cmd_error
);

  localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int NB_CNT         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'('h4C);
  localparam logic [NB_BYTE-1:0] CMD_CONT = NB_BYTE'('h43);
  localparam logic [NB_BYTE-1:0] CMD_STEP_MODE = NB_BYTE'('h53);
  localparam logic [NB_BYTE-1:0] CMD_NEXT = NB_BYTE'('h4E);

  typedef enum logic [NB_STATE-1:0] {
    IDLE       = NB_STATE'(0),
    READ_COUNT = NB_STATE'(1),
    READ_BYTE  = NB_STATE'(2)
  } state_t;

  state_t              state_reg;
  logic [NB_ADDR-1:0]  word_idx_reg;
  logic [NB_ADDR-1:0]  word_count_reg;
  logic [NB_CNT-1:0]   byte_cnt_reg;
  logic [NB_DATA-1:0]  assembly_reg;

  logic [NB_DATA-1:0]  word_next;
  logic [NB_ADDR-1:0]  word_idx_next;
  logic                last_byte;
  logic                last_word;

  // Incoming byte lands in the low lane; earlier bytes move up, so after
  // BYTES_PER_WORD bytes the first one received sits in the MSB lane.
  always_comb begin
    word_next     = {assembly_reg[NB_DATA-NB_BYTE-1:0], i_uart_rx_data};
    word_idx_next = word_idx_reg + NB_ADDR'(1);
    last_byte     = (byte_cnt_reg == NB_CNT'(BYTES_PER_WORD - 1));
    last_word     = (word_idx_next == word_count_reg);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg         <= IDLE;
      word_idx_reg      <= '0;
      word_count_reg    <= '0;
      byte_cnt_reg      <= '0;
      assembly_reg      <= '0;
      o_instr_mem_wr_en <= 1'b0;
      o_instr_mem_addr  <= '0;
      o_instr_mem_data  <= '0;
      o_execution_mode  <= 1'b0;
      o_start           <= 1'b0;
      o_step            <= 1'b0;
      o_running         <= 1'b0;
      o_program_loaded  <= 1'b0;
      o_cmd_error       <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      o_instr_mem_wr_en <= 1'b0;
      o_start           <= 1'b0;
      o_step            <= 1'b0;
      o_cmd_error       <= 1'b0;

      if (i_uart_rx_done) begin
        case (state_reg)
          IDLE: begin
            case (i_uart_rx_data)
              CMD_LOAD: begin
                // Overwriting memory under a live pipeline is refused.
                if (o_running) begin
                  o_cmd_error <= 1'b1;
                end else begin
                  o_program_loaded <= 1'b0;
                  word_idx_reg     <= '0;
                  state_reg        <= READ_COUNT;
                end
              end
              CMD_CONT, CMD_STEP_MODE: begin
                if (o_program_loaded && !o_running) begin
                  o_execution_mode <= (i_uart_rx_data == CMD_STEP_MODE);
                  o_start          <= 1'b1;
                  o_running        <= 1'b1;
                end else begin
                  o_cmd_error <= 1'b1;
                end
              end
              CMD_NEXT: begin
                // A halt arriving together with the step wins: the step is
                // dropped without flagging an error.
                if (!i_halt) begin
                  if (o_running && o_execution_mode) begin
                    o_step <= 1'b1;
                  end else begin
                    o_cmd_error <= 1'b1;
                  end
                end
              end
              default: o_cmd_error <= 1'b1;
            endcase
          end

          READ_COUNT: begin
            word_count_reg <= NB_ADDR'(i_uart_rx_data);
            byte_cnt_reg   <= '0;
            if (i_uart_rx_data == '0) begin
              o_program_loaded <= 1'b1;
              state_reg        <= IDLE;
            end else begin
              state_reg <= READ_BYTE;
            end
          end

          READ_BYTE: begin
            assembly_reg <= word_next;
            if (last_byte) begin
              o_instr_mem_wr_en <= 1'b1;
              o_instr_mem_addr  <= word_idx_reg;
              o_instr_mem_data  <= word_next;
              word_idx_reg      <= word_idx_next;
              byte_cnt_reg      <= '0;
              if (last_word) begin
                o_program_loaded <= 1'b1;
                state_reg        <= IDLE;
              end
            end else begin
              byte_cnt_reg <= byte_cnt_reg + NB_CNT'(1);
            end
          end

          default: state_reg <= IDLE;
        endcase
      end

      // Halt overrides any run request seen in the same cycle.
      if (i_halt) begin
        o_running <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_debug_unit_receive.sv
// ---------------------------------------------------------------------------
// tb_debug_unit_receive
//   Scoreboard bench: every byte sent pushes the pulse it should cause
//   (write, start, step or error, with the cycle it must appear in); a
//   negedge monitor pops and compares each pulse the DUT produces.
//   Level outputs are checked directly after the relevant bytes.
// ---------------------------------------------------------------------------
module tb_debug_unit_receive;

  localparam int NB_DATA = 32;
  localparam int NB_BYTE = 8;
  localparam int NB_ADDR = 8;

  localparam logic [3:0] EV_WR    = 4'd1;
  localparam logic [3:0] EV_START = 4'd2;
  localparam logic [3:0] EV_STEP  = 4'd3;
  localparam logic [3:0] EV_ERR   = 4'd4;

  logic               clock;
  logic               reset;
  logic [NB_BYTE-1:0] rx_data;
  logic               rx_done;
  logic               halt;
  logic               wr_en;
  logic [NB_ADDR-1:0] addr;
  logic [NB_DATA-1:0] data;
  logic               mode;
  logic               start;
  logic               step;
  logic               running;
  logic               loaded;
  logic               cmd_error;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  int unsigned cyc      = 0;
  logic [63:0] sb_q[$];

  debug_unit_receive dut (
    .i_clock           (clock),
    .i_reset           (reset),
    .i_uart_rx_data    (rx_data),
    .i_uart_rx_done    (rx_done),
    .i_halt            (halt),
    .o_instr_mem_wr_en (wr_en),
    .o_instr_mem_addr  (addr),
    .o_instr_mem_data  (data),
    .o_execution_mode  (mode),
    .o_start           (start),
    .o_step            (step),
    .o_running         (running),
    .o_program_loaded  (loaded),
    .o_cmd_error       (cmd_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] make_ev(input logic [3:0] kind, input logic [7:0] a,
                                          input logic [31:0] d, input int unsigned c);
    return {4'h0, kind, a, d, c[15:0]};
  endfunction

  task automatic observe(input string tag, input logic [63:0] ev);
    logic [63:0] exp;
    if (sb_q.size() == 0) begin
      check_val({"unexpected_", tag}, ev, 64'h0);
    end else begin
      exp = sb_q.pop_front();
      check_val(tag, ev, exp);
    end
  endtask

  // Pulse monitor, sampled half a cycle after the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (wr_en)     observe("write", make_ev(EV_WR, addr, data, cyc));
      if (start)     observe("start", make_ev(EV_START, {7'b0, mode}, 32'h0, cyc));
      if (step)      observe("step",  make_ev(EV_STEP, 8'h0, 32'h0, cyc));
      if (cmd_error) observe("error", make_ev(EV_ERR, 8'h0, 32'h0, cyc));
    end
  end

  // Drive one byte for one cycle; optionally raise halt in that same cycle.
  // exp_kind=0 means the byte must produce no pulse.
  task automatic send(input logic [7:0] b, input logic with_halt,
                      input logic [3:0] exp_kind, input logic [7:0] ea, input logic [31:0] ed);
    @(negedge clock);
    rx_data = b;
    rx_done = 1'b1;
    halt    = with_halt;
    if (exp_kind != 4'd0) sb_q.push_back(make_ev(exp_kind, ea, ed, cyc + 1));
    @(negedge clock);
    rx_done = 1'b0;
    halt    = 1'b0;
  endtask

  task automatic send_plain(input logic [7:0] b);
    send(b, 1'b0, 4'd0, 8'h0, 32'h0);
  endtask

  task automatic send_err(input logic [7:0] b);
    send(b, 1'b0, EV_ERR, 8'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_val("reset_outputs",
              {52'h0, wr_en, addr != 8'h0, data != 32'h0, mode, start, step, running,
               loaded, cmd_error, 3'b0}, 64'h0);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;
    halt    = 1'b0;
    repeat (3) @(posedge clock);
    do_reset();

    // Rejections with no program resident.
    send_err(8'h7A);
    send_err(8'h43);
    send_err(8'h53);
    send_err(8'h4E);
    check_val("running_after_errs", {63'h0, running}, 64'h0);

    // Two-word load.
    send_plain(8'h4C);
    send_plain(8'h02);
    send_plain(8'h00);
    send_plain(8'h00);
    send_plain(8'h00);
    send(8'h01, 1'b0, EV_WR, 8'h00, 32'h0000_0001);
    check_val("loaded_mid_load", {63'h0, loaded}, 64'h0);
    send_plain(8'hDE);
    send_plain(8'hAD);
    send_plain(8'hBE);
    send(8'hEF, 1'b0, EV_WR, 8'h01, 32'hDEAD_BEEF);
    check_val("loaded_after_load", {63'h0, loaded}, 64'h1);

    // Step mode: start then two steps; no load while running.
    send(8'h53, 1'b0, EV_START, 8'h01, 32'h0);
    check_val("running_step_mode", {62'h0, running, mode}, 64'h3);
    send(8'h4E, 1'b0, EV_STEP, 8'h0, 32'h0);
    send(8'h4E, 1'b0, EV_STEP, 8'h0, 32'h0);
    send_err(8'h4C);
    send_err(8'h43);

    // Step coinciding with halt: silently dropped, pipeline stops.
    send(8'h4E, 1'b1, 4'd0, 8'h0, 32'h0);
    check_val("halt_collision", {61'h0, running, mode, loaded}, 64'h3);

    // Empty load, then continuous run.
    send_plain(8'h4C);
    check_val("loaded_cleared_by_L", {63'h0, loaded}, 64'h0);
    send_plain(8'h00);
    check_val("empty_load", {63'h0, loaded}, 64'h1);
    send(8'h43, 1'b0, EV_START, 8'h00, 32'h0);
    check_val("running_cont", {62'h0, running, mode}, 64'h2);
    send_err(8'h4E);

    // Standalone halt pulse; mode holds.
    @(negedge clock);
    halt = 1'b1;
    @(negedge clock);
    halt = 1'b0;
    check_val("halt_pulse", {62'h0, running, mode}, 64'h0);

    // Reset part-way through a load: first word written, then abort.
    send_plain(8'h4C);
    send_plain(8'h02);
    send_plain(8'h12);
    send_plain(8'h34);
    send_plain(8'h56);
    send(8'h78, 1'b0, EV_WR, 8'h00, 32'h1234_5678);
    send_plain(8'h9A);
    do_reset();
    // These would complete word 1 if the load survived; in IDLE they are junk.
    send_err(8'hAA);
    send_err(8'hBB);
    send_err(8'hCC);
    check_val("loaded_after_abort", {63'h0, loaded}, 64'h0);
    send_err(8'h43);

    repeat (3) @(negedge clock);
    check_val("scoreboard_drained", 64'(sb_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
